zjh_seg_scan: RTL and testbench

ZJH_SEG_SCAN -- requirements
Module: zjh_seg_scan

---
 rtl/zjh_seg_pkg.sv | 31 +++
 rtl/zjh_seg_scan_if.sv | 14 +
 rtl/zjh_bcd7seg.sv | 15 +
 rtl/zjh_seg_scan.sv | 88 ++++++++
 tb/tb_zjh_seg_scan.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/zjh_seg_pkg.sv
// Shared types and constants for the zjh 4-digit multiplexed 7-segment scanner.
package zjh_seg_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned DIG_N = 4;

  typedef logic [BCD_W-1:0] bcd_t;
  typedef logic [SEG_W-1:0] seg_t;
  typedef logic [DIG_N-1:0] dig_t;

  // Shadow register layout: d3 is the most significant digit.
  typedef struct packed {
    bcd_t d3;
    bcd_t d2;
    bcd_t d1;
    bcd_t d0;
  } bcd4_t;

  localparam seg_t SEG_BLANK = 7'b0000000;
  localparam dig_t DIG_OFF   = 4'b1111;

  // 4511-style decode, L[6]=a .. L[0]=g; codes 10..15 are dark.
  localparam seg_t SEG_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b0000000, 7'b0000000,
    7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
  };

endpackage

// File: rtl/zjh_seg_scan_if.sv
// Data-in / display-out bundle between the counter stage and the scanner.
interface zjh_seg_scan_if;

  logic [15:0] Din;
  logic        LE;
  logic        BLZ;
  logic [6:0]  L;
  logic [3:0]  DIG;
  logic        FRAME;

  modport master (output Din, LE, BLZ, input L, DIG, FRAME);
  modport slave  (input Din, LE, BLZ, output L, DIG, FRAME);

endinterface

// File: rtl/zjh_bcd7seg.sv
// Combinational BCD to 7-segment decoder with a blank override.
module zjh_bcd7seg
  import zjh_seg_pkg::*;
(
  input  bcd_t i_code,
  input  logic i_blank,
  output seg_t o_seg_c
);

  always_comb begin
    o_seg_c = SEG_TABLE[i_code];
    if (i_blank) o_seg_c = SEG_BLANK;
  end

endmodule

// File: rtl/zjh_seg_scan.sv
// Four-digit multiplexed 7-segment scanner: shadow register, prescaler,
// digit index, leading-zero blanking and registered segment/digit drive.
module zjh_seg_scan
  import zjh_seg_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4000,
  parameter int unsigned BLANK_CYC = 1
) (
  input  logic           Clk,
  input  logic           MR,
  zjh_seg_scan_if.slave  bus
);

  localparam int unsigned PRE_W = 16;
  localparam int unsigned IDX_W = 2;

  logic [PRE_W-1:0] r_pre,   w_pre_nxt;
  logic [IDX_W-1:0] r_idx,   w_idx_nxt;
  bcd4_t            r_shadow, w_shadow_nxt;
  seg_t             r_seg,   w_seg_nxt;
  dig_t             r_dig,   w_dig_nxt;
  logic             r_frame, w_frame_nxt;

  logic             w_wrap;
  logic             w_zb3, w_zb2, w_zb1;
  bcd_t             w_code;
  logic             w_blank;
  seg_t             w_seg_dec;

  zjh_bcd7seg u_dec (
    .i_code  (w_code),
    .i_blank (w_blank),
    .o_seg_c (w_seg_dec)
  );

  // Leading-zero chain: a digit may blank only if every digit above it did.
  always_comb begin
    w_zb3 = bus.BLZ && (r_shadow.d3 == 4'd0);
    w_zb2 = w_zb3   && (r_shadow.d2 == 4'd0);
    w_zb1 = w_zb2   && (r_shadow.d1 == 4'd0);
    w_code  = r_shadow.d0;
    w_blank = 1'b0;
    case (r_idx)
      2'd1: begin w_code = r_shadow.d1; w_blank = w_zb1; end
      2'd2: begin w_code = r_shadow.d2; w_blank = w_zb2; end
      2'd3: begin w_code = r_shadow.d3; w_blank = w_zb3; end
      default: begin w_code = r_shadow.d0; w_blank = 1'b0; end
    endcase
  end

  // Next-state: outputs are derived from this cycle's index/prescaler/shadow.
  always_comb begin
    w_wrap       = (r_pre == PRE_W'(CLK_DIV - 1));
    w_pre_nxt    = w_wrap ? '0 : r_pre + PRE_W'(1);
    w_idx_nxt    = w_wrap ? r_idx + IDX_W'(1) : r_idx;
    w_frame_nxt  = w_wrap && (r_idx == 2'd3);
    w_shadow_nxt = bus.LE ? bcd4_t'(bus.Din) : r_shadow;
    w_dig_nxt    = DIG_OFF;
    w_seg_nxt    = SEG_BLANK;
    if (r_pre >= PRE_W'(BLANK_CYC)) begin
      w_dig_nxt = ~(4'b0001 << r_idx);
      w_seg_nxt = w_seg_dec;
    end
  end

  always_ff @(posedge Clk or posedge MR) begin
    if (MR) begin
      r_pre    <= '0;
      r_idx    <= '0;
      r_shadow <= '0;
      r_seg    <= SEG_BLANK;
      r_dig    <= DIG_OFF;
      r_frame  <= 1'b0;
    end else begin
      r_pre    <= w_pre_nxt;
      r_idx    <= w_idx_nxt;
      r_shadow <= w_shadow_nxt;
      r_seg    <= w_seg_nxt;
      r_dig    <= w_dig_nxt;
      r_frame  <= w_frame_nxt;
    end
  end

  assign bus.L     = r_seg;
  assign bus.DIG   = r_dig;
  assign bus.FRAME = r_frame;

endmodule

// File: tb/tb_zjh_seg_scan.sv
// Directed bench for zjh_seg_scan with CLK_DIV=4, BLANK_CYC=1.
module tb_zjh_seg_scan;

  localparam int CDIV  = 4;
  localparam int BLANK = 1;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S6 = 7'b1011111;
  localparam logic [6:0] S7 = 7'b1110000;
  localparam logic [6:0] S8 = 7'b1111111;
  localparam logic [6:0] S9 = 7'b1111011;
  localparam logic [6:0] SX = 7'b0000000;

  typedef struct {
    logic [15:0] din;
    logic        blz;
    logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
  } vec_t;

  logic Clk = 1'b0;
  logic MR;
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t vecs [11];

  zjh_seg_scan_if bus ();

  zjh_seg_scan #(.CLK_DIV(CDIV), .BLANK_CYC(BLANK)) u_dut (
    .Clk (Clk),
    .MR  (MR),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    cmp({tag, " DIG"},   32'(bus.DIG),   32'h0000000F);
    cmp({tag, " L"},     32'(bus.L),     32'h00000000);
    cmp({tag, " FRAME"}, 32'(bus.FRAME), 32'h00000000);
  endtask

  // Outputs after edge k (k=1 is the first edge after reset release).
  task automatic run(input int k0, input int k1, input logic [27:0] segs, input string tag);
    int          c, pre, idx;
    logic [3:0]  e_dig;
    logic [6:0]  e_l;
    logic        e_fr;
    for (int k = k0; k <= k1; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      bus.LE = 1'b0;
      c   = k - 1;
      pre = c % CDIV;
      idx = (c / CDIV) % 4;
      if (pre < BLANK) begin
        e_dig = 4'b1111;
        e_l   = 7'b0000000;
      end else begin
        e_dig = ~(4'b0001 << idx);
        e_l   = segs[idx*7 +: 7];
      end
      e_fr = ((k % 16) == 0);
      cmp($sformatf("%s k%0d DIG", tag, k),   32'(bus.DIG),   32'(e_dig));
      cmp($sformatf("%s k%0d L", tag, k),     32'(bus.L),     32'(e_l));
      cmp($sformatf("%s k%0d FRAME", tag, k), 32'(bus.FRAME), 32'(e_fr));
    end
  endtask

  // Reset, then load din on the first edge after release.
  task automatic do_reset(input logic [15:0] din, input logic blz, input string tag);
    @(negedge Clk);
    MR      = 1'b1;
    bus.Din = din;
    bus.BLZ = blz;
    bus.LE  = 1'b1;
    #1;
    check_reset_outs({tag, " rst"});
    @(negedge Clk);
    MR = 1'b0;
  endtask

  initial begin
    MR      = 1'b1;
    bus.Din = 16'h0000;
    bus.LE  = 1'b0;
    bus.BLZ = 1'b0;

    vecs[0]  = '{16'h1234, 1'b0, {S1, S2, S3, S4}};
    vecs[1]  = '{16'h0005, 1'b1, {SX, SX, SX, S5}};
    vecs[2]  = '{16'h0005, 1'b0, {S0, S0, S0, S5}};
    vecs[3]  = '{16'h0A07, 1'b0, {S0, SX, S0, S7}};
    vecs[4]  = '{16'h0000, 1'b1, {SX, SX, SX, S0}};
    vecs[5]  = '{16'h5678, 1'b1, {S5, S6, S7, S8}};
    vecs[6]  = '{16'h9000, 1'b1, {S9, S0, S0, S0}};
    vecs[7]  = '{16'h0090, 1'b1, {SX, SX, S9, S0}};
    vecs[8]  = '{16'h0F00, 1'b1, {SX, SX, S0, S0}};
    vecs[9]  = '{16'h0102, 1'b1, {SX, S1, S0, S2}};
    vecs[10] = '{16'h0A07, 1'b1, {SX, SX, S0, S7}};

    for (int v = 0; v < 11; v++) begin
      do_reset(vecs[v].din, vecs[v].blz, $sformatf("vec%0d", v));
      run(1, 33, vecs[v].segs, $sformatf("vec%0d", v));
    end

    // Reset asserted mid-slot clears outputs without a clock, then restarts at digit 0.
    do_reset(16'h1234, 1'b0, "mr");
    run(1, 10, {S1, S2, S3, S4}, "mr_pre");
    @(posedge Clk);
    #2 MR = 1'b1;
    #1 check_reset_outs("mr_async");
    @(negedge Clk);
    MR = 1'b0;
    run(1, 17, {S0, S0, S0, S0}, "mr_post");

    // Load mid-slot in digit1: old value for one more cycle, then new data.
    do_reset(16'h1234, 1'b0, "le_mid");
    run(1, 6, {S1, S2, S3, S4}, "le_mid_a");
    bus.Din = 16'h9999;
    bus.LE  = 1'b1;
    run(7, 7, {S1, S2, S3, S4}, "le_mid_b");
    run(8, 17, {S9, S9, S9, S9}, "le_mid_c");

    // Load on the same edge as the wrap into digit1.
    do_reset(16'h1234, 1'b0, "le_wrap");
    run(1, 3, {S1, S2, S3, S4}, "le_wrap_a");
    bus.Din = 16'h9999;
    bus.LE  = 1'b1;
    run(4, 4, {S1, S2, S3, S4}, "le_wrap_b");
    run(5, 20, {S9, S9, S9, S9}, "le_wrap_c");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
